car_velocity_engine: RTL and testbench

CAR_VELOCITY_ENGINE -- requirements
Module: car_velocity_engine

---
 rtl/car_velocity_engine.sv | 153 +++++++++++++++
 tb/tb_car_velocity_engine.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/car_velocity_engine.sv
// Per-car velocity integrator with friction and saturation, followed by a
// serial binary-to-BCD conversion of each car's displayed speed.
module car_velocity_engine #(
  parameter  int NUM_CARS   = 2,
  parameter  int VEL_INT_W  = 4,
  parameter  int VEL_FRAC_W = 6,
  parameter  int ACC_W      = 8,
  parameter  int VEL_MAX    = 7,
  parameter  int FRIC_SHIFT = 6,
  localparam int VW         = VEL_INT_W + VEL_FRAC_W,
  localparam int CW         = (NUM_CARS > 1) ? $clog2(NUM_CARS) : 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_frame_tick,
  input  logic [NUM_CARS*ACC_W-1:0] i_acc,
  input  logic                      i_vel_load,
  input  logic [CW-1:0]             i_vel_load_id,
  input  logic [VW-1:0]             i_vel_load_val,
  output logic [NUM_CARS*VW-1:0]    o_vel,
  output logic [NUM_CARS*12-1:0]    o_bcd,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_overrun
);

  localparam int OW   = VW - 3;
  localparam int VLIM = VEL_MAX << VEL_FRAC_W;
  localparam int BW   = $clog2(OW + 1);
  localparam logic signed [VW+1:0] VLIM_X = (VW+2)'(VLIM);

  typedef enum logic [1:0] {S_IDLE, S_UPDATE, S_CONVERT, S_DONE} state_t;

  state_t                  r_state, w_state_nxt;
  logic [CW-1:0]           r_car;
  logic [BW-1:0]           r_bit;
  logic signed [ACC_W-1:0] r_acc     [NUM_CARS];
  logic signed [VW-1:0]    r_vel     [NUM_CARS];
  logic [11:0]             r_bcd_out [NUM_CARS];
  logic [OW-1:0]           r_bin;
  logic [11:0]             r_bcd;
  logic                    r_ovr;

  logic                    w_last_car, w_last_bit, w_ld_ok;
  logic signed [VW-1:0]    w_v_cur, w_upd, w_ld;
  logic signed [VW+1:0]    w_s, w_f;
  logic [VW-1:0]           w_abs;
  logic [OW-1:0]           w_m, w_bin_src, w_bin_nxt;
  logic [11:0]             w_bcd_src, w_bcd_adj, w_bcd_nxt;

  function automatic logic signed [VW-1:0] clamp(input logic signed [VW+1:0] x);
    if (x > VLIM_X)       return VW'(VLIM_X);
    else if (x < -VLIM_X) return VW'(-VLIM_X);
    else                  return VW'(x);
  endfunction

  assign w_last_car = (r_car == CW'(NUM_CARS - 1));
  assign w_last_bit = (r_bit == BW'(OW - 1));
  assign w_ld_ok    = ({1'b0, i_vel_load_id} < (CW+1)'(NUM_CARS));
  assign w_v_cur    = r_vel[r_car];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (i_frame_tick) w_state_nxt = S_UPDATE;
      S_UPDATE:  if (w_last_car) w_state_nxt = S_CONVERT;
      S_CONVERT: if (w_last_car && w_last_bit) w_state_nxt = S_DONE;
      S_DONE:    w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_s   = (VW+2)'(w_v_cur) + (VW+2)'(r_acc[r_car]);
    w_f   = w_s - (w_s >>> FRIC_SHIFT);
    w_upd = clamp(w_f);
    w_ld  = clamp((VW+2)'($signed(i_vel_load_val)));
  end

  // First bit of each car's conversion pulls the magnitude straight from the
  // velocity register, so a load landing before that cycle is honoured.
  always_comb begin
    w_abs     = w_v_cur[VW-1] ? -w_v_cur : w_v_cur;
    w_m       = OW'(w_abs >> 3);
    w_bin_src = (r_bit == '0) ? w_m : r_bin;
    w_bcd_src = (r_bit == '0) ? '0 : r_bcd;
    w_bcd_adj = w_bcd_src;
    for (int unsigned d = 0; d < 3; d++) begin
      if (w_bcd_src[d*4 +: 4] >= 4'd5) w_bcd_adj[d*4 +: 4] = w_bcd_src[d*4 +: 4] + 4'd3;
    end
    w_bcd_nxt = 12'({w_bcd_adj, w_bin_src[OW-1]});
    w_bin_nxt = w_bin_src << 1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_car <= '0;
      r_bit <= '0;
      r_bin <= '0;
      r_bcd <= '0;
      r_ovr <= 1'b0;
      for (int unsigned k = 0; k < NUM_CARS; k++) begin
        r_acc[k]     <= '0;
        r_vel[k]     <= '0;
        r_bcd_out[k] <= '0;
      end
    end else begin
      r_ovr <= i_frame_tick && (r_state != S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (i_frame_tick) begin
            for (int unsigned k = 0; k < NUM_CARS; k++) r_acc[k] <= i_acc[k*ACC_W +: ACC_W];
            r_car <= '0;
            r_bit <= '0;
          end
        end
        S_UPDATE: begin
          r_vel[r_car] <= w_upd;
          r_car        <= w_last_car ? '0 : r_car + 1'b1;
        end
        S_CONVERT: begin
          r_bin <= w_bin_nxt;
          r_bcd <= w_bcd_nxt;
          if (w_last_bit) begin
            r_bcd_out[r_car] <= w_bcd_nxt;
            r_bit            <= '0;
            r_car            <= w_last_car ? '0 : r_car + 1'b1;
          end else begin
            r_bit <= r_bit + 1'b1;
          end
        end
        default: ;
      endcase
      // Placed last so an override beats the same car's update on this edge.
      if (i_vel_load && w_ld_ok) r_vel[i_vel_load_id] <= w_ld;
    end
  end

  for (genvar k = 0; k < NUM_CARS; k++) begin : g_out
    assign o_vel[k*VW +: VW] = r_vel[k];
    assign o_bcd[k*12 +: 12] = r_bcd_out[k];
  end

  assign o_busy    = (r_state != S_IDLE);
  assign o_done    = (r_state == S_DONE);
  assign o_overrun = r_ovr;

endmodule

// File: tb/tb_car_velocity_engine.sv
// Bench for car_velocity_engine at default parameters: directed table,
// multi-cycle corner sequences and randomized frames against an integer model.
module tb_car_velocity_engine;
  localparam int VW = 10;

  logic        clk = 1'b0;
  logic        rst_n, tick, ld;
  logic [15:0] acc;
  logic [0:0]  ld_id;
  logic [9:0]  ld_val;
  logic [19:0] vel;
  logic [23:0] bcd;
  logic        busy, done, ovr;

  always #5 clk = ~clk;

  car_velocity_engine #(
    .NUM_CARS(2), .VEL_INT_W(4), .VEL_FRAC_W(6), .ACC_W(8), .VEL_MAX(7), .FRIC_SHIFT(6)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_frame_tick(tick), .i_acc(acc),
    .i_vel_load(ld), .i_vel_load_id(ld_id), .i_vel_load_val(ld_val),
    .o_vel(vel), .o_bcd(bcd), .o_busy(busy), .o_done(done), .o_overrun(ovr)
  );

  typedef struct {
    int v0, v1, a0, a1;
    int ev0, ev1, eb0, eb1;
  } vec_t;

  vec_t        tbl[6];
  int          checks = 0;
  int          errors = 0;
  int          done_cyc, done_cnt, ovr_cyc, ovr_cnt;
  logic [23:0] bcd_mid;
  logic        busy_c1, busy_c20;
  int          m_vel[2];

  task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic signed [31:0] vel_of(input int k);
    logic signed [VW-1:0] v;
    v = vel[k*VW +: VW];
    return 32'(v);
  endfunction

  function automatic logic [31:0] bcd_of(input int k);
    return 32'(bcd[k*12 +: 12]);
  endfunction

  function automatic int clampv(input int x);
    if (x > 448)  return 448;
    if (x < -448) return -448;
    return x;
  endfunction

  function automatic int floor64(input int s);
    if (s >= 0) return s / 64;
    return -((-s + 63) / 64);
  endfunction

  function automatic int bcd_exp(input int v);
    int m;
    m = (v < 0 ? -v : v) / 8;
    return (m / 100) * 256 + ((m / 10) % 10) * 16 + (m % 10);
  endfunction

  task automatic model_frame(input int a0, input int a1);
    int s;
    s = m_vel[0] + a0; m_vel[0] = clampv(s - floor64(s));
    s = m_vel[1] + a1; m_vel[1] = clampv(s - floor64(s));
  endtask

  task automatic do_load(input int id, input int val);
    ld = 1'b1; ld_id = 1'(id); ld_val = 10'(val);
    @(negedge clk);
    ld = 1'b0;
  endtask

  task automatic set_acc(input int a0, input int a1);
    acc = {8'(a1), 8'(a0)};
  endtask

  // Cycle c is the c-th negedge after the accepting posedge; inputs driven in
  // cycle c are sampled at the edge that closes it.
  task automatic run_frame(input int ld_cyc, input int lid, input int lval,
                           input int tk_cyc, input int rst_cyc, input int glitch_cyc);
    done_cyc = -1; done_cnt = 0; ovr_cyc = -1; ovr_cnt = 0;
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    for (int c = 1; c <= 24; c++) begin
      #1;
      if (done === 1'b1) begin done_cnt++; if (done_cyc < 0) done_cyc = c; end
      if (ovr === 1'b1)  begin ovr_cnt++;  if (ovr_cyc < 0)  ovr_cyc = c;  end
      if (c == 15) bcd_mid = bcd;
      if (c == 1)  busy_c1 = busy;
      if (c == 20) busy_c20 = busy;
      ld = (c == ld_cyc);
      if (c == ld_cyc) begin ld_id = 1'(lid); ld_val = 10'(lval); end
      tick = (c == tk_cyc);
      if (c == rst_cyc) rst_n = 1'b0;
      if (c == glitch_cyc) acc = 16'($urandom);
      @(negedge clk);
    end
    ld = 1'b0; tick = 1'b0;
  endtask

  task automatic chk_frame(input string nm, input int ev0, input int ev1, input int eb0, input int eb1);
    chk({nm, "_vel0"}, vel_of(0), ev0);
    chk({nm, "_vel1"}, vel_of(1), ev1);
    chk({nm, "_bcd0"}, bcd_of(0), eb0);
    chk({nm, "_bcd1"}, bcd_of(1), eb1);
    chk({nm, "_done_cyc"}, done_cyc, 17);
    chk({nm, "_done_cnt"}, done_cnt, 1);
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    tbl[0] = '{v0:    0, v1:    0, a0:  64, a1:    0, ev0:   63, ev1:    0, eb0: 'h007, eb1: 'h000};
    tbl[1] = '{v0:    0, v1:  448, a0:   0, a1:   64, ev0:    0, ev1:  448, eb0: 'h000, eb1: 'h056};
    tbl[2] = '{v0: -448, v1:    0, a0:   0, a1:  -64, ev0: -441, ev1:  -63, eb0: 'h055, eb1: 'h007};
    tbl[3] = '{v0:  511, v1: -512, a0:   0, a1: -128, ev0:  441, ev1: -448, eb0: 'h055, eb1: 'h056};
    tbl[4] = '{v0:  100, v1:   -1, a0:  -1, a1:    0, ev0:   98, ev1:    0, eb0: 'h012, eb1: 'h000};
    tbl[5] = '{v0:   -7, v1:  447, a0: 127, a1:    1, ev0:  119, ev1:  441, eb0: 'h014, eb1: 'h055};

    rst_n = 1'b0; tick = 1'b0; ld = 1'b0; ld_id = '0; ld_val = '0; acc = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_vel", vel, 0);
    chk("rst_bcd", bcd, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ovr", ovr, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      do_load(0, tbl[i].v0);
      do_load(1, tbl[i].v1);
      set_acc(tbl[i].a0, tbl[i].a1);
      run_frame(-1, 0, 0, -1, -1, -1);
      chk_frame($sformatf("tbl%0d", i), tbl[i].ev0, tbl[i].ev1, tbl[i].eb0, tbl[i].eb1);
    end

    // Late tick, acc change after capture, bcd hold until car1 finishes.
    do_load(0, 0); do_load(1, 0);
    set_acc(64, 64);
    run_frame(-1, 0, 0, 3, -1, 1);
    chk_frame("ovr", 63, 63, 'h007, 'h007);
    chk("ovr_cnt", ovr_cnt, 1);
    chk("ovr_cyc", ovr_cyc, 4);
    chk("hold_bcd0", 32'(bcd_mid[11:0]), 'h007);
    chk("hold_bcd1", 32'(bcd_mid[23:12]), tbl[5].eb1);
    chk("busy_c1", busy_c1, 1);
    chk("busy_c20", busy_c20, 0);

    do_load(0, 0); do_load(1, 0);
    set_acc(0, 64);
    run_frame(2, 1, 100, -1, -1, -1);
    chk_frame("collide", 0, 100, 'h000, 'h012);

    do_load(0, 0); do_load(1, 0);
    set_acc(0, 0);
    run_frame(5, 1, -200, -1, -1, -1);
    chk_frame("convload", 0, -200, 'h000, 'h025);

    do_load(0, 50); do_load(1, 50);
    set_acc(64, 64);
    run_frame(-1, 0, 0, -1, 10, -1);
    #1;
    chk("abort_done_cnt", done_cnt, 0);
    chk("abort_vel", vel, 0);
    chk("abort_bcd", bcd, 0);
    chk("abort_busy", busy, 0);
    chk("abort_ovr", ovr, 0);
    rst_n = 1'b1;
    @(negedge clk);
    set_acc(64, 0);
    run_frame(-1, 0, 0, -1, -1, -1);
    chk_frame("clean", 63, 0, 'h007, 'h000);

    m_vel[0] = 63; m_vel[1] = 0;
    for (int r = 0; r < 25; r++) begin
      int a0, a1, val;
      for (int k = 0; k < 2; k++) begin
        if ($urandom_range(0, 1) == 1) begin
          val = int'($urandom_range(0, 1023)) - 512;
          do_load(k, val);
          m_vel[k] = clampv(val);
        end
      end
      a0 = int'($urandom_range(0, 255)) - 128;
      a1 = int'($urandom_range(0, 255)) - 128;
      set_acc(a0, a1);
      model_frame(a0, a1);
      run_frame(-1, 0, 0, -1, -1, -1);
      chk_frame($sformatf("rnd%0d", r), m_vel[0], m_vel[1], bcd_exp(m_vel[0]), bcd_exp(m_vel[1]));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
